// File: rtl/core_pkg.sv
// Shared core types and constants.
// Imported by the fetch stage and its buffer.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two ring of {instr, pc} entries.
// Clear has priority over push/pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          flush;

    assign flush  = reset || clear;
    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Space is reserved at request time; a push into a full buffer is a bug.
    always_ff @(posedge clk) begin
        if (!flush) begin
            assert (!(push && !do_pop && count == CW'(DEPTH)));
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues sequential word reads,
// buffers responses and hands {instr, pc} to decode.
module ifetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            pop;
    logic            push;
    logic            flush;
    logic [CW:0]     occ;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    resp;

    assign flush = reset || redirect_valid;
    assign pop   = id_valid && id_ready;
    assign push  = inflight && !flush;

    // Occupancy credits a same-cycle pop so back-to-back fetch never stalls.
    assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    assign imem_req  = !flush && (occ < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign id_valid = (count != '0) && !redirect_valid;
    assign instr    = (count != '0) ? head.instr : NOP;
    assign pc       = (count != '0) ? head.pc : '0;

    assign resp.instr = imem_rdata;
    assign resp.pc    = inflight_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_valid),
        .push     (push),
        .push_data(resp),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (imem_addr[1:0] == 2'b00);
        end
    end

endmodule
